// File: rtl/color_bbox_detect.sv
// color_bbox_detect
//   Thresholds one channel of a 24-bit saliency stream and accumulates the bounding box
//   and hit count of above-threshold pixels over each frame. It reports them at the next
//   frame start (i_vsync rising edge). The video is forwarded with a fixed 2-cycle latency.
//   The previous frame's box is drawn as a rectangle outline.
//
// Ports
//   pixelclk, reset_n            clock, asynchronous active-low reset
//   din, i_hsync, i_vsync, i_de  input video (i_vsync rising edge = frame start)
//   cfg_thresh                   hit threshold, captured at each frame start
//   overlay_en                   1 = draw the box outline on dout
//   dout, o_hsync, o_vsync, o_de output video, 2 cycles behind the inputs
//   box_valid                    one-cycle pulse when the box_* / hit_count outputs update
//   box_found                    previous frame's hit count >= MIN_PIXELS
//   box_xmin/xmax/ymin/ymax      inclusive box bounds (all 0 when not found)
//   hit_count                    previous frame's hit count
module color_bbox_detect #(
    parameter int unsigned    DW         = 24,
    parameter int unsigned    XW         = 12,
    parameter int unsigned    YW         = 12,
    parameter int unsigned    CW         = 20,
    parameter int unsigned    CH_SEL     = 0,
    parameter int unsigned    MIN_PIXELS = 16,
    parameter logic [DW-1:0]  BOX_COLOR  = 24'h00FF00
) (
    input  logic          pixelclk,
    input  logic          reset_n,
    input  logic [DW-1:0] din,
    input  logic          i_hsync,
    input  logic          i_vsync,
    input  logic          i_de,
    input  logic [7:0]    cfg_thresh,
    input  logic          overlay_en,
    output logic [DW-1:0] dout,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic          box_valid,
    output logic          box_found,
    output logic [XW-1:0] box_xmin,
    output logic [XW-1:0] box_xmax,
    output logic [YW-1:0] box_ymin,
    output logic [YW-1:0] box_ymax,
    output logic [CW-1:0] hit_count
);

    localparam logic [1:0] StWaitFrame = 2'd0;
    localparam logic [1:0] StAccum     = 2'd1;
    localparam logic [1:0] StReport    = 2'd2;

    localparam logic [XW-1:0] X_MAX   = '1;
    localparam logic [YW-1:0] Y_MAX   = '1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);

    // Edge detectors and coordinate counters
    logic          vsync_q, de_q;
    logic          vs_rise, de_fall;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign vs_rise = i_vsync & ~vsync_q;
    assign de_fall = de_q & ~i_de;

    // x_q is the coordinate of the current de pixel; it advances after each one.
    always_comb begin
        x_d = '0;
        if (i_de) begin
            x_d = (x_q == X_MAX) ? x_q : x_q + XW'(1);
        end
    end

    always_comb begin
        y_d = y_q;
        if (vs_rise) begin
            y_d = '0;
        end else if (de_fall && (y_q != Y_MAX)) begin
            y_d = y_q + YW'(1);
        end
    end

    // Hit detection on the selected channel
    logic [7:0] thr_q, thr_d;
    logic [7:0] chan;
    logic       hit;

    assign chan = din[8*(2-CH_SEL) +: 8];
    assign hit  = i_de & (chan >= thr_q);

    // Accumulator FSM
    logic [1:0]    state_q, state_d;
    logic [XW-1:0] acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
    logic [YW-1:0] acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d;

    logic          box_valid_d, box_found_d;
    logic [XW-1:0] box_xmin_d, box_xmax_d;
    logic [YW-1:0] box_ymin_d, box_ymax_d;
    logic [CW-1:0] hit_count_d;
    logic          found;

    assign found = (acc_cnt_q >= MIN_CNT);

    always_comb begin
        state_d     = state_q;
        thr_d       = thr_q;
        acc_xmin_d  = acc_xmin_q;
        acc_xmax_d  = acc_xmax_q;
        acc_ymin_d  = acc_ymin_q;
        acc_ymax_d  = acc_ymax_q;
        acc_cnt_d   = acc_cnt_q;
        box_valid_d = 1'b0;
        box_found_d = box_found;
        box_xmin_d  = box_xmin;
        box_xmax_d  = box_xmax;
        box_ymin_d  = box_ymin;
        box_ymax_d  = box_ymax;
        hit_count_d = hit_count;

        case (state_q)
            StWaitFrame: begin
                if (vs_rise) begin
                    thr_d      = cfg_thresh;
                    acc_xmin_d = '0;
                    acc_xmax_d = '0;
                    acc_ymin_d = '0;
                    acc_ymax_d = '0;
                    acc_cnt_d  = '0;
                    state_d    = StAccum;
                end
            end
            StAccum: begin
                if (vs_rise) begin
                    // Threshold is taken on the true vsync edge; bounds are held for REPORT.
                    thr_d   = cfg_thresh;
                    state_d = StReport;
                end else if (hit) begin
                    // A zero count means no hit yet this frame (the count saturates, never wraps).
                    if (acc_cnt_q == '0) begin
                        acc_xmin_d = x_q;
                        acc_xmax_d = x_q;
                        acc_ymin_d = y_q;
                        acc_ymax_d = y_q;
                    end else begin
                        if (x_q < acc_xmin_q) acc_xmin_d = x_q;
                        if (x_q > acc_xmax_q) acc_xmax_d = x_q;
                        if (y_q < acc_ymin_q) acc_ymin_d = y_q;
                        if (y_q > acc_ymax_q) acc_ymax_d = y_q;
                    end
                    if (acc_cnt_q != CNT_MAX) begin
                        acc_cnt_d = acc_cnt_q + CW'(1);
                    end
                end
            end
            StReport: begin
                box_valid_d = 1'b1;
                box_found_d = found;
                box_xmin_d  = found ? acc_xmin_q : '0;
                box_xmax_d  = found ? acc_xmax_q : '0;
                box_ymin_d  = found ? acc_ymin_q : '0;
                box_ymax_d  = found ? acc_ymax_q : '0;
                hit_count_d = acc_cnt_q;
                acc_xmin_d  = '0;
                acc_xmax_d  = '0;
                acc_ymin_d  = '0;
                acc_ymax_d  = '0;
                acc_cnt_d   = '0;
                state_d     = StAccum;
            end
            default: begin
                state_d = StWaitFrame;
            end
        endcase
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q    <= 1'b0;
            de_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            thr_q      <= '0;
            state_q    <= StWaitFrame;
            acc_xmin_q <= '0;
            acc_xmax_q <= '0;
            acc_ymin_q <= '0;
            acc_ymax_q <= '0;
            acc_cnt_q  <= '0;
            box_valid  <= 1'b0;
            box_found  <= 1'b0;
            box_xmin   <= '0;
            box_xmax   <= '0;
            box_ymin   <= '0;
            box_ymax   <= '0;
            hit_count  <= '0;
        end else begin
            vsync_q    <= i_vsync;
            de_q       <= i_de;
            x_q        <= x_d;
            y_q        <= y_d;
            thr_q      <= thr_d;
            state_q    <= state_d;
            acc_xmin_q <= acc_xmin_d;
            acc_xmax_q <= acc_xmax_d;
            acc_ymin_q <= acc_ymin_d;
            acc_ymax_q <= acc_ymax_d;
            acc_cnt_q  <= acc_cnt_d;
            box_valid  <= box_valid_d;
            box_found  <= box_found_d;
            box_xmin   <= box_xmin_d;
            box_xmax   <= box_xmax_d;
            box_ymin   <= box_ymin_d;
            box_ymax   <= box_ymax_d;
            hit_count  <= hit_count_d;
        end
    end

    // Video path: stage 1 captures pixel, syncs and position; stage 2 applies the outline.
    logic [DW-1:0] pix1_q;
    logic          hs1_q, vs1_q, de1_q;
    logic [XW-1:0] x1_q;
    logic [YW-1:0] y1_q;
    logic          in_x, in_y, on_x, on_y, edge_px;

    assign in_x    = (x1_q >= box_xmin) && (x1_q <= box_xmax);
    assign in_y    = (y1_q >= box_ymin) && (y1_q <= box_ymax);
    assign on_x    = (x1_q == box_xmin) || (x1_q == box_xmax);
    assign on_y    = (y1_q == box_ymin) || (y1_q == box_ymax);
    assign edge_px = box_found & overlay_en & de1_q & ((on_x & in_y) | (on_y & in_x));

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            pix1_q  <= '0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            de1_q   <= 1'b0;
            x1_q    <= '0;
            y1_q    <= '0;
            dout    <= '0;
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_de    <= 1'b0;
        end else begin
            pix1_q  <= din;
            hs1_q   <= i_hsync;
            vs1_q   <= i_vsync;
            de1_q   <= i_de;
            x1_q    <= x_q;
            y1_q    <= y_q;
            dout    <= edge_px ? BOX_COLOR : pix1_q;
            o_hsync <= hs1_q;
            o_vsync <= vs1_q;
            o_de    <= de1_q;
        end
    end

endmodule
